// File: rtl/lvds_video_pkg.sv
// lvds_video_pkg: default panel timing, colour constants and coordinate/pixel types
package lvds_video_pkg;
    typedef logic [10:0] coord_t;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 24;
    localparam int DEF_H_BP     = 10;
    localparam int DEF_V_ACTIVE = 800;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 6;
    localparam rgb_t BLACK   = 24'h000000;
    localparam rgb_t BLUE    = 24'h0000FF;
    localparam rgb_t RED     = 24'hFF0000;
    localparam rgb_t MAGENTA = 24'hFF00FF;
    localparam rgb_t GREEN   = 24'h00FF00;
    localparam rgb_t CYAN    = 24'h00FFFF;
    localparam rgb_t YELLOW  = 24'hFFFF00;
    localparam rgb_t WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_COLORS [8] = '{BLACK, BLUE, RED, MAGENTA, GREEN, CYAN, YELLOW, WHITE};
endpackage

// File: rtl/lvds_color_bar.sv
// lvds_color_bar: maps a pixel column to one of eight colour bars, one register stage
module lvds_color_bar
    import lvds_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic   clk,
    input  logic   rst,
    input  coord_t x,
    output rgb_t   rgb
);
    localparam int BW = H_ACTIVE / 8;
    logic [2:0] idx;
    // the last bar swallows the remainder columns
    always_comb idx = (x >= coord_t'(7 * BW)) ? 3'd7 : 3'(x / coord_t'(BW));
    always_ff @(posedge clk or posedge rst)
        if (rst) rgb <= BLACK;
        else     rgb <= BAR_COLORS[idx];
endmodule

// File: rtl/lvds_timing_gen.sv
// lvds_timing_gen: LVDS panel timing generator with 2-cycle output pipeline.
// Define LVDS_TEST_PATTERN_EN to compile in the colour-bar generator.
module lvds_timing_gen
    import lvds_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pattern_en,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start,
    output logic        line_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
    localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);
    coord_t h_cnt, v_cnt;
    logic h_wrap;
    logic de1, hs1, vs1, fs1, ls1;
    rgb_t src;
    always_comb h_wrap = h_cnt == H_LAST;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 11'd1;
            if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
        end
    assign x = h_cnt;
    assign y = v_cnt;
    // stage 1: decode position; en low drains the pipe to idle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            de1 <= 1'b0;
            hs1 <= 1'b0;
            vs1 <= 1'b0;
            fs1 <= 1'b0;
            ls1 <= 1'b0;
        end else begin
            de1 <= en && h_cnt < H_ACT && v_cnt < V_ACT;
            hs1 <= en && h_cnt >= HS_BEG && h_cnt < HS_END;
            vs1 <= en && v_cnt >= VS_BEG && v_cnt < VS_END;
            fs1 <= en && h_cnt == '0 && v_cnt == '0;
            ls1 <= en && h_cnt == '0 && v_cnt < V_ACT;
        end
`ifdef LVDS_TEST_PATTERN_EN
    rgb_t bar;
    logic pat1;
    lvds_color_bar #(.H_ACTIVE(H_ACTIVE)) u_bar (
        .clk (clk),
        .rst (rst),
        .x   (h_cnt),
        .rgb (bar)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) pat1 <= 1'b0;
        else     pat1 <= pattern_en;
    always_comb src = pat1 ? bar : {pix_r, pix_g, pix_b};
`else
    logic unused_pattern_en;
    assign unused_pattern_en = pattern_en;
    always_comb src = {pix_r, pix_g, pix_b};
`endif
    // stage 2: pixel data arrives here, one cycle after x/y were presented
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            {red, green, blue} <= '0;
        end else begin
            de          <= de1;
            hsync       <= hs1 ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs1 ? SYNC_POL : ~SYNC_POL;
            frame_start <= fs1;
            line_start  <= ls1;
            {red, green, blue} <= de1 ? src : '0;
        end
endmodule

// File: tb/tb_lvds_timing_gen.sv
// tb_lvds_timing_gen: randomized bench with a position-based reference model, small timing
module tb_lvds_timing_gen;
    localparam int HA = 16, HF = 2, HS = 2, HB = 2;
    localparam int VA = 8, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
`ifdef LVDS_TEST_PATTERN_EN
    localparam bit PATTERN = 1'b1;
`else
    localparam bit PATTERN = 1'b0;
`endif
    localparam logic [23:0] BARS [8] = '{24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                                         24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};
    typedef struct packed {
        logic de, hs, vs, fs, ls;
        logic [23:0] rgb;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, pattern_en = 1'b0;
    logic [7:0] pix_r = '0, pix_g = '0, pix_b = '0;
    logic [10:0] x, y;
    logic hsync, vsync, de, frame_start, line_start;
    logic [7:0] red, green, blue;
    exp_t q[$];
    int pos = 0;
    int n_cmp = 0, n_bad = 0;
    int de_cnt = 0, fs_cnt = 0, ls_cnt = 0;
    logic [10:0] px, py;
    lvds_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pattern_en(pattern_en),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue),
        .frame_start(frame_start), .line_start(line_start)
    );
    always #5 clk = ~clk;
    function automatic exp_t idle();
        exp_t e;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction
    function automatic exp_t predict(int p, logic e_n, logic pat);
        exp_t e;
        int h, v, bi;
        e = idle();
        if (!e_n) return e;
        h = p % HT;
        v = p / HT;
        e.de = h < HA && v < VA;
        e.hs = !(h >= HA + HF && h < HA + HF + HS);
        e.vs = !(v >= VA + VF && v < VA + VF + VS);
        e.fs = p == 0;
        e.ls = h == 0 && v < VA;
        bi = h / (HA / 8);
        if (bi > 7) bi = 7;
        if (e.de) e.rgb = (PATTERN && pat) ? BARS[bi] : {h[7:0], v[7:0], 8'hA5};
        return e;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    task automatic reset_check();
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_ls", 32'(line_start), 32'd0);
    endtask
    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pos = 0;
        q.delete();
        q.push_back(idle());
        q.push_back(idle());
    endtask
    task automatic step(input logic e_n, input logic pat);
        exp_t e;
        en = e_n;
        pattern_en = pat;
        q.push_back(predict(pos, e_n, pat));
        @(negedge clk);
        chk("x", 32'(x), 32'(pos % HT));
        chk("y", 32'(y), 32'(pos / HT));
        e = q.pop_front();
        chk("de", 32'(de), 32'(e.de));
        chk("hsync", 32'(hsync), 32'(e.hs));
        chk("vsync", 32'(vsync), 32'(e.vs));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("line_start", 32'(line_start), 32'(e.ls));
        chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
        de_cnt += int'(de);
        fs_cnt += int'(frame_start);
        ls_cnt += int'(line_start);
        px = x;
        py = y;
        @(posedge clk);
        #1;
        {pix_r, pix_g, pix_b} = {px[7:0], py[7:0], 8'hA5};
        pos = e_n ? (pos + 1) % (HT * VT) : 0;
    endtask
    initial begin
        repeat (3) begin
            @(negedge clk);
            reset_check();
        end
        release_rst();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        de_cnt = 0;
        fs_cnt = 0;
        ls_cnt = 0;
        repeat (HT * VT) step(1'b1, 1'($urandom_range(0, 1)));
        chk("de_per_frame", 32'(de_cnt), 32'(HA * VA));
        chk("fs_per_frame", 32'(fs_cnt), 32'd1);
        chk("ls_per_frame", 32'(ls_cnt), 32'(VA));
        while (pos != 3 * HT + 5) step(1'b1, 1'($urandom_range(0, 1)));
        repeat (4) step(1'b0, 1'($urandom_range(0, 1)));
        repeat (300) step(1'b1, 1'($urandom_range(0, 1)));
        repeat (600) step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)));
        while (pos != 4 * HT + 7) step(1'b1, 1'($urandom_range(0, 1)));
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            reset_check();
            @(posedge clk);
        end
        release_rst();
        repeat (300) step(1'b1, 1'($urandom_range(0, 1)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lvds_timing_gen.md
LVDS_TIMING_GEN -- requirements
Module: lvds_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 24, hsync width
- H_BP, 10, horizontal back porch
- V_ACTIVE, 800, active lines
- V_FP, 3, vertical front porch
- V_SYNC, 3, vsync width
- V_BP, 6, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)

REQ-002 Ports SHALL be, one per line:
- clk, in, 1, dot clock; single clock domain
- rst, in, 1, reset; asynchronous, active-high
- en, in, 1, run enable (DCM locked)
- pattern_en, in, 1, select colour-bar pattern
- pix_r, in, 8, red from upstream source
- pix_g, in, 8, green from upstream source
- pix_b, in, 8, blue from upstream source
- x, out, 11, pixel column to fetch
- y, out, 11, pixel line to fetch
- hsync, out, 1, horizontal sync to LVDS encoder
- vsync, out, 1, vertical sync to LVDS encoder
- de, out, 1, data enable
- red, out, 8, red to LVDS encoder
- green, out, 8, green to LVDS encoder
- blue, out, 8, blue to LVDS encoder
- frame_start, out, 1, one-cycle pulse with output pixel (0,0)
- line_start, out, 1, one-cycle pulse with output pixel (0,y) of each active line

Function
REQ-003 The block SHALL define H_TOTAL as H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL as V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-004 While en=1, h_cnt SHALL increment every clock and wrap from H_TOTAL-1 to 0.
REQ-005 v_cnt SHALL increment only on an h_cnt wrap and SHALL itself wrap from V_TOTAL-1 to 0 in that same cycle.
REQ-006 Outputs x and y SHALL equal the registered h_cnt and v_cnt (stage 0, cycle t).
REQ-007 pix_r, pix_g and pix_b SHALL be sampled at t+1, which gives the upstream source exactly one cycle of read latency.
REQ-008 de, hsync, vsync, red, green, blue, frame_start and line_start SHALL be registered and SHALL describe the stage-0 position with a fixed latency of 2 cycles (valid at t+2).
REQ-009 de SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-010 hsync SHALL be at its active level iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line.
REQ-011 vsync SHALL be at its active level iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for the whole line.
REQ-012 When de=0, red, green and blue SHALL be 0.
REQ-013 When de=1 and the pattern is not selected, red, green and blue SHALL equal pix_r, pix_g and pix_b.
REQ-014 When en=0, h_cnt and v_cnt SHALL be forced to 0 at the next edge.
REQ-015 When en=0, the pipeline SHALL flush to idle: de=0, syncs inactive, rgb=0, no pulses.
REQ-016 When en rises, the first output pixel SHALL be (0,0), 2 cycles later, accompanied by frame_start.
REQ-017 pattern_en SHALL be sampled at stage 0 only; a mid-line change SHALL take effect on pixel boundaries with no glitches in syncs or de.

Reset
REQ-018 While rst=1, h_cnt, v_cnt, x, y, de, red, green, blue, frame_start and line_start SHALL be 0.
REQ-019 While rst=1, hsync and vsync SHALL be at their inactive level (~SYNC_POL).
REQ-020 Reset asserted mid-frame SHALL abort the frame immediately; after release with en=1 the block SHALL restart at (0,0).

Configuration
REQ-021 Macro LVDS_TEST_PATTERN_EN defined: a colour-bar generator SHALL be compiled in.
- When pattern_en=1 and de=1, the screen SHALL be divided into 8 bars of width H_ACTIVE/8.
- Bar order from the left, in {R,G,B}: black, blue, red, magenta, green, cyan, yellow, white; each component 8'h00 or 8'hFF.
- The last bar SHALL absorb any remainder columns.
REQ-022 Macro LVDS_TEST_PATTERN_EN undefined: pattern_en SHALL be ignored, the data path SHALL always pass pix_*, and no bar logic SHALL be present; latency is unchanged.

Structure
REQ-023 Package lvds_video_pkg SHALL hold the default timing constants, the colour constants (black through white) and the 11-bit coordinate type.
REQ-024 Sub-module lvds_color_bar SHALL map x to an RGB triple through one register stage; it is instantiated only under LVDS_TEST_PATTERN_EN.

Verification
Benches use small timing (H 16/2/2/2, V 8/1/1/1, H_TOTAL=22, V_TOTAL=11) unless noted.
REQ-025 rst released, en=1 -> frame_start at cycle 2; de high for 16 cycles per line, 8 lines; next frame_start after 242 cycles.
REQ-026 SYNC_POL=0 -> hsync low exactly for h_cnt 18..19; vsync low for whole line 9; both high during reset.
REQ-027 Upstream model returns pix={x[7:0],y[7:0],8'hA5} one cycle after x,y -> red/green/blue match the x,y of the same pixel on every de cycle; rgb=0 when de=0.
REQ-028 en dropped at (5,3) for 4 cycles, then raised -> outputs idle 2 cycles after the drop; restart at (0,0) with frame_start.
REQ-029 LVDS_TEST_PATTERN_EN defined, pattern_en=1, default timing -> x=0 gives 000000, x=160 gives 0000FF, x=480 gives FF00FF, x=1279 gives FFFFFF; undefined -> pix passthrough.
REQ-030 rst pulsed at line 4 mid-line -> all outputs at reset values during rst; clean (0,0) restart after release.
